cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 read_enable  input  1  memory-stage load request, held until ready=1.
REQ-005 write_enable  input  1  memory-stage store request, held until ready=1.
REQ-006 address  input  32  byte address of the request; bits [1:0] ignored.
REQ-007 write_data  input  32  store data.
REQ-008 read_data  output  32  load data, valid while ready=1 for a read.
REQ-009 ready  output  1  request completes in this cycle; 0 stalls the pipeline.
REQ-010 sram_read_enable  output  1  read request to the SRAM controller.
REQ-011 sram_write_enable  output  1  write request to the SRAM controller.
REQ-012 sram_address  output  32  passthrough of address.
REQ-013 sram_write_data  output  32  passthrough of write_data.
REQ-014 sram_read_data  input  32  SRAM controller read data, valid when sram_ready=1.
REQ-015 sram_ready  input  1  SRAM controller completion.

Function
REQ-016 Organisation SHALL be 2-way set-associative, 64 sets, one 32-bit word per line.
- Per way: valid bit, 10-bit tag, 32-bit data.
- Per set: 1 LRU bit giving the way to replace.
REQ-017 Index and tag SHALL be derived from A = {address[31:2],2'b0} - 1024 (32-bit, wrap ignored).
- index = A[7:2].
- tag = A[17:8].
REQ-018 Hit SHALL mean valid and tag-equal in a way; way0 wins if both match.
REQ-019 FSM states SHALL be IDLE, READ_MISS and WRITE.
REQ-020 IDLE transitions:
- read_enable with miss -> READ_MISS.
- write_enable (read_enable low) -> WRITE.
- Otherwise stay in IDLE.
REQ-021 If read_enable and write_enable are both high, the read SHALL take priority.
REQ-022 Read hit in IDLE:
- ready=1 and read_data = hit way data, same cycle, zero added latency.
- No SRAM request.
- LRU updated at the clock edge.
REQ-023 ready SHALL be 0 in IDLE on a read miss or any write, and 1 in IDLE with no request.
REQ-024 sram_read_enable SHALL be 1 in IDLE on a read miss and throughout READ_MISS.
REQ-025 sram_write_enable SHALL be 1 in IDLE on a write and throughout WRITE.
REQ-026 Both sram enables SHALL be 0 otherwise.
REQ-027 In READ_MISS and WRITE, ready SHALL equal sram_ready.
REQ-028 In READ_MISS, read_data SHALL equal sram_read_data.
REQ-029 READ_MISS SHALL return to IDLE on the edge where sram_ready=1; on that edge the line SHALL be filled:
- valid=1, tag and data written.
- Victim way is the first invalid way (way0 first), else the LRU way.
REQ-030 WRITE SHALL return to IDLE on the edge where sram_ready=1.
REQ-031 Write policy SHALL be write-through, no-write-allocate.
- Write hit updates the hit-way data on the edge leaving IDLE.
- Write miss leaves the cache unchanged.
REQ-032 LRU update on read hit, write hit or fill: LRU bit SHALL point to the way not accessed.
REQ-033 With sram_ready held 0, READ_MISS and WRITE SHALL be held indefinitely with enables asserted.
REQ-034 Read-miss latency against the 7-cycle SRAM controller SHALL be: request in cycle 0, ready=1 in cycle 7, back in IDLE in cycle 8.
- Write latency SHALL be identical.

Reset
REQ-035 While rst=1, at the clock edge:
- State -> IDLE.
- All valid bits and LRU bits -> 0.
REQ-036 While rst=1, outputs SHALL be ready=1, sram_read_enable=0 and sram_write_enable=0.
REQ-037 Reset mid-miss or mid-write SHALL abandon the operation with no line filled; the SRAM controller shares rst.

Verification
REQ-038 Reset scenario: assert rst 2 cycles -> ready=1, enables 0; every read then misses.
REQ-039 Read miss then hit:
- Read 0x400, SRAM returns 0xDEADBEEF -> ready=0 in cycles 0-6, ready=1 with read_data=0xDEADBEEF in cycle 7.
- Repeat read 0x400 -> ready=1 in cycle 0, sram_read_enable=0.
REQ-040 LRU eviction:
- Read 0x400, read 0x500, read 0x400 (hit), then read 0x600 (miss, evicts 0x500).
- Then read 0x400 hits and read 0x500 misses.
REQ-041 Write-through:
- Write 0x12345678 to cached 0x400 -> sram_write_enable=1 until sram_ready; read 0x400 then hits with 0x12345678.
- Write to uncached 0x700 -> SRAM write; read 0x700 then misses.
REQ-042 Reset mid-miss: read 0x400 miss, rst in cycle 3 -> next cycle IDLE, enables 0, ready=1; read 0x400 misses again.
REQ-043 Simultaneous enables: read_enable=write_enable=1 on a miss -> sram_read_enable=1, sram_write_enable=0.

Source files
------------

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through / no-write-allocate cache in front of an
// SRAM controller. Read hits complete combinationally; misses and writes stall.
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        sram_read_enable,
  output logic        sram_write_enable,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [31:0] sram_read_data,
  input  logic        sram_ready
);

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

  state_t      state;
  logic [63:0] valid0, valid1, lru;
  logic [9:0]  tag0  [64];
  logic [9:0]  tag1  [64];
  logic [31:0] data0 [64];
  logic [31:0] data1 [64];

  logic [15:0] a_word;
  logic [5:0]  idx;
  logic [9:0]  tag;
  logic        hit0, hit1, hit, hit_way, victim;
  logic [31:0] hit_data;

  // Bits [17:0] of (addr - 1024) depend only on addr[17:0], so the
  // word-aligned subtraction is done on the 16 bits that feed index and tag.
  assign a_word   = address[17:2] - 16'd256;
  assign idx      = a_word[5:0];
  assign tag      = a_word[15:6];

  assign hit0     = valid0[idx] && (tag0[idx] == tag);
  assign hit1     = valid1[idx] && (tag1[idx] == tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = !hit0;
  assign hit_data = hit0 ? data0[idx] : data1[idx];
  assign victim   = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);

  assign sram_address    = address;
  assign sram_write_data = write_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_enable) begin
            if (hit) lru[idx] <= ~hit_way;
            else     state    <= READ_MISS;
          end else if (write_enable) begin
            state <= WRITE;
            if (hit) begin
              if (hit_way) data1[idx] <= write_data;
              else         data0[idx] <= write_data;
              lru[idx] <= ~hit_way;
            end
          end
        end
        READ_MISS: begin
          if (sram_ready) begin
            state <= IDLE;
            if (victim) begin
              valid1[idx] <= 1'b1;
              tag1[idx]   <= tag;
              data1[idx]  <= sram_read_data;
            end else begin
              valid0[idx] <= 1'b1;
              tag0[idx]   <= tag;
              data0[idx]  <= sram_read_data;
            end
            lru[idx] <= ~victim;
          end
        end
        WRITE: begin
          if (sram_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend on the current request so that read hits add no latency.
  always_comb begin
    ready             = 1'b1;
    read_data         = '0;
    sram_read_enable  = 1'b0;
    sram_write_enable = 1'b0;
    case (state)
      IDLE: begin
        if (read_enable) begin
          if (hit) begin
            read_data = hit_data;
          end else begin
            ready            = 1'b0;
            sram_read_enable = 1'b1;
          end
        end else if (write_enable) begin
          ready             = 1'b0;
          sram_write_enable = 1'b1;
        end
      end
      READ_MISS: begin
        ready            = sram_ready;
        read_data        = sram_read_data;
        sram_read_enable = 1'b1;
      end
      WRITE: begin
        ready             = sram_ready;
        sram_write_enable = 1'b1;
      end
      default: ready = 1'b1;
    endcase
    if (rst) begin
      ready             = 1'b1;
      sram_read_enable  = 1'b0;
      sram_write_enable = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: 7-cycle SRAM controller model, scoreboard of
// expected read data and completion latency per request.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        read_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        sram_read_enable;
  logic        sram_write_enable;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;
  logic        sram_ready;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  logic [31:0] mem [logic [31:0]];
  int          cnt = 0;
  logic        stall = 1'b0;

  cache_controller dut (
    .clk               (clk),
    .rst               (rst),
    .read_enable       (read_enable),
    .write_enable      (write_enable),
    .address           (address),
    .write_data        (write_data),
    .read_data         (read_data),
    .ready             (ready),
    .sram_read_enable  (sram_read_enable),
    .sram_write_enable (sram_write_enable),
    .sram_address      (sram_address),
    .sram_write_data   (sram_write_data),
    .sram_read_data    (sram_read_data),
    .sram_ready        (sram_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (mem.exists(k)) return mem[k];
    return k ^ 32'hC0DE_0000;
  endfunction

  // SRAM controller: completes 7 cycles after the request first appears.
  always_comb sram_read_data = mem_rd(sram_address);
  assign sram_ready = (sram_read_enable || sram_write_enable) && !stall && (cnt == 7);

  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else if ((sram_read_enable || sram_write_enable) && !stall) begin
      if (cnt == 7) begin
        cnt <= 0;
        if (sram_write_enable) mem[{sram_address[31:2], 2'b00}] = sram_write_data;
      end else cnt <= cnt + 1;
    end else if (!(sram_read_enable || sram_write_enable)) cnt <= 0;
  end

  task automatic run_req(input logic [31:0] a, input logic [31:0] wd, input bit is_read,
                         input bit both, input bit exp_hit, input string nm);
    logic [31:0] exp_d;
    logic [1:0]  exp_en;
    int          exp_lat;
    int          cyc;
    bit          en_ok;
    if (is_read) exp_q.push_back(mem_rd(a));
    lat_q.push_back((is_read && exp_hit) ? 0 : 7);
    exp_en = is_read ? (exp_hit ? 2'b00 : 2'b10) : 2'b01;
    @(negedge clk);
    address = a; write_data = wd;
    read_enable = is_read; write_enable = !is_read || both;
    #1;
    total++;
    if ({sram_read_enable, sram_write_enable} !== exp_en) begin
      bad++; $display("FAIL %s/en0: got %b want %b", nm, {sram_read_enable, sram_write_enable}, exp_en);
    end
    total++;
    if (sram_address !== a) begin
      bad++; $display("FAIL %s/addr: got %h want %h", nm, sram_address, a);
    end
    cyc = 0; en_ok = 1'b1;
    while (ready !== 1'b1 && cyc < 40) begin
      @(negedge clk); #1; cyc++;
      if ({sram_read_enable, sram_write_enable} !== exp_en) en_ok = 1'b0;
    end
    total++;
    if (!en_ok) begin
      bad++; $display("FAIL %s/en_hold: got dropped want %b", nm, exp_en);
    end
    exp_lat = lat_q.pop_front();
    total++;
    if (cyc !== exp_lat) begin
      bad++; $display("FAIL %s/latency: got %0d want %0d", nm, cyc, exp_lat);
    end
    if (is_read) begin
      exp_d = exp_q.pop_front();
      total++;
      if (read_data !== exp_d) begin
        bad++; $display("FAIL %s/data: got %h want %h", nm, read_data, exp_d);
      end
    end
    @(posedge clk); #1;
    read_enable = 1'b0; write_enable = 1'b0;
    #1;
    total++;
    if ({ready, sram_read_enable, sram_write_enable} !== 3'b100) begin
      bad++; $display("FAIL %s/idle: got %b want 100", nm, {ready, sram_read_enable, sram_write_enable});
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; read_enable = 1'b1; address = 32'h400;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if ({ready, sram_read_enable, sram_write_enable} !== 3'b100) begin
        bad++; $display("FAIL reset%0d: got %b want 100", i, {ready, sram_read_enable, sram_write_enable});
      end
      @(negedge clk);
    end
    rst = 1'b0; read_enable = 1'b0;
    run_req(32'h400, '0, 1'b1, 1'b0, 1'b0, "reset_miss");
  endtask

  task automatic test_read_miss_hit();
    do_reset();
    run_req(32'h400, '0, 1'b1, 1'b0, 1'b0, "rmh_miss");
    run_req(32'h400, '0, 1'b1, 1'b0, 1'b1, "rmh_hit");
  endtask

  task automatic test_lru();
    do_reset();
    run_req(32'h400, '0, 1'b1, 1'b0, 1'b0, "lru_400");
    run_req(32'h500, '0, 1'b1, 1'b0, 1'b0, "lru_500");
    run_req(32'h400, '0, 1'b1, 1'b0, 1'b1, "lru_400h");
    run_req(32'h600, '0, 1'b1, 1'b0, 1'b0, "lru_600");
    run_req(32'h400, '0, 1'b1, 1'b0, 1'b1, "lru_400h2");
    run_req(32'h500, '0, 1'b1, 1'b0, 1'b0, "lru_500m");
  endtask

  task automatic test_write_through();
    do_reset();
    run_req(32'h400, '0, 1'b1, 1'b0, 1'b0, "wt_fill");
    run_req(32'h400, 32'h1234_5678, 1'b0, 1'b0, 1'b0, "wt_wr_hit");
    run_req(32'h400, '0, 1'b1, 1'b0, 1'b1, "wt_rd_hit");
    run_req(32'h700, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, "wt_wr_miss");
    run_req(32'h700, '0, 1'b1, 1'b0, 1'b0, "wt_rd_miss");
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    @(negedge clk); read_enable = 1'b1; address = 32'h400;
    repeat (3) @(negedge clk);
    rst = 1'b1; #1;
    total++;
    if ({ready, sram_read_enable, sram_write_enable} !== 3'b100) begin
      bad++; $display("FAIL mid_rst: got %b want 100", {ready, sram_read_enable, sram_write_enable});
    end
    @(posedge clk); #1;
    rst = 1'b0; read_enable = 1'b0; #1;
    total++;
    if ({ready, sram_read_enable, sram_write_enable} !== 3'b100) begin
      bad++; $display("FAIL mid_after: got %b want 100", {ready, sram_read_enable, sram_write_enable});
    end
    run_req(32'h400, '0, 1'b1, 1'b0, 1'b0, "mid_remiss");
  endtask

  task automatic test_simultaneous();
    run_req(32'h800, 32'h5555_AAAA, 1'b1, 1'b1, 1'b0, "both_miss");
  endtask

  task automatic test_stall();
    int cyc;
    stall = 1'b1;
    @(negedge clk); write_enable = 1'b1; address = 32'h900; write_data = 32'h0BAD_F00D;
    repeat (20) @(negedge clk);
    #1;
    total++;
    if ({ready, sram_read_enable, sram_write_enable} !== 3'b001) begin
      bad++; $display("FAIL stall_hold: got %b want 001", {ready, sram_read_enable, sram_write_enable});
    end
    stall = 1'b0;
    cyc = 0;
    while (ready !== 1'b1 && cyc < 40) begin
      @(negedge clk); #1; cyc++;
    end
    total++;
    if (cyc !== 7) begin
      bad++; $display("FAIL stall_release: got %0d want 7", cyc);
    end
    @(posedge clk); #1; write_enable = 1'b0;
    run_req(32'h900, '0, 1'b1, 1'b0, 1'b0, "stall_rd");
  endtask

  initial begin
    mem[32'h400] = 32'hDEAD_BEEF;
    test_reset();
    test_read_miss_hit();
    test_lru();
    test_write_through();
    test_reset_mid_miss();
    test_simultaneous();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
